// File: rtl/vc_router_pkg.sv
// vc_router_pkg
// Shared types and defaults for the virtual-channel router blocks.
//   vc_id_t          : VC identifier for the default NUM_VC
//   credit_t         : per-VC downstream credit count for the default CREDIT_DEPTH
//   NUM_VC_DEF       : default number of virtual channels
//   CREDIT_DEPTH_DEF : default downstream buffer depth per VC
// FLIT_DATA_WIDTH is normally supplied by VR_define.vh; a fallback value is
// provided here so the package stands on its own when that header is absent.

`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

package vc_router_pkg;

    localparam int NUM_VC_DEF       = 4;
    localparam int CREDIT_DEPTH_DEF = 8;

    typedef logic [$clog2(NUM_VC_DEF)-1:0]         vc_id_t;
    typedef logic [$clog2(CREDIT_DEPTH_DEF+1)-1:0] credit_t;

endpackage

// File: rtl/vc_fifo_scheduler_rr_arbiter.sv
// rr_arbiter
// Parameterised N-way round-robin arbiter (combinational).
//   req         : request vector, one bit per requester
//   ptr         : requester with highest priority this cycle
//   grant       : one-hot grant (all zero when nothing requests)
//   grant_id    : index of the granted requester (0 when none)
//   next_ptr    : pointer value to load after a grant (winner + 1, wrapping)
//   grant_valid : a grant was issued
// N must be a power of two so the index arithmetic wraps naturally.

module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_id,
    output logic [W-1:0] next_ptr,
    output logic         grant_valid
);

    logic [W-1:0] idx_s;
    logic         hit_s;

    // Walk the requesters starting at ptr; the first request seen wins.
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        next_ptr    = ptr;
        grant_valid = 1'b0;
        idx_s       = '0;
        hit_s       = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx_s           = ptr + W'(i);
            hit_s           = req[idx_s] & ~grant_valid;
            grant[idx_s]    = grant[idx_s] | hit_s;
            grant_id        = hit_s ? idx_s : grant_id;
            next_ptr        = hit_s ? (idx_s + W'(1)) : next_ptr;
            grant_valid     = grant_valid | hit_s;
        end
    end

endmodule

// File: rtl/vc_fifo_scheduler.sv
// vc_fifo_scheduler
// Round-robin scheduler sharing one output link among NUM_VC virtual-channel
// FIFOs, with per-VC downstream credit tracking.
//   clk, reset  : clock and synchronous active-high reset
//   enable      : scheduling enable (credits still return when low)
//   fifo_empty  : per-VC FIFO empty flags
//   fifo_data   : per-VC FWFT head data, VC k at [k*DATA_W +: DATA_W]
//   fifo_pop    : one-hot pop, combinational from current state
//   credit_in   : per-VC credit return pulses
//   out_valid/out_vc/out_data : registered flit on the output link
//   credit_err  : sticky flag, credit returned into a full counter
//   starve_flag : (only with VC_SCHED_STARVE_CNT_EN) per-VC starvation diagnostic
// Optional feature macro: VC_SCHED_STARVE_CNT_EN

module vc_fifo_scheduler
    import vc_router_pkg::*;
#(
    parameter int NUM_VC       = NUM_VC_DEF,
    parameter int CREDIT_DEPTH = CREDIT_DEPTH_DEF,
    parameter int DATA_W       = `FLIT_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NUM_VC-1:0]          fifo_empty,
    input  logic [NUM_VC*DATA_W-1:0]   fifo_data,
    output logic [NUM_VC-1:0]          fifo_pop,
    input  logic [NUM_VC-1:0]          credit_in,
    output logic                       out_valid,
    output logic [$clog2(NUM_VC)-1:0]  out_vc,
    output logic [DATA_W-1:0]          out_data,
    output logic                       credit_err
`ifdef VC_SCHED_STARVE_CNT_EN
    ,
    output logic [NUM_VC-1:0]          starve_flag
`endif
);

    localparam int VC_W   = $clog2(NUM_VC);
    localparam int CRED_W = $clog2(CREDIT_DEPTH + 1);

    logic [CRED_W-1:0] credit_r [NUM_VC];
    logic [VC_W-1:0]   rr_ptr_r;
    logic [NUM_VC-1:0] eligible_s;
    logic [NUM_VC-1:0] grant_s;
    logic [VC_W-1:0]   grant_id_s;
    logic [VC_W-1:0]   next_ptr_s;
    logic              grant_valid_s;

    // Eligibility; reset masks it so no pop escapes while reset is high.
    always_comb begin
        eligible_s = '0;
        for (int k = 0; k < NUM_VC; k++) begin
            eligible_s[k] = enable & ~reset & ~fifo_empty[k] &
                            (credit_r[k] != CRED_W'(0));
        end
    end

    rr_arbiter #(
        .N (NUM_VC),
        .W (VC_W)
    ) u_arb (
        .req         (eligible_s),
        .ptr         (rr_ptr_r),
        .grant       (grant_s),
        .grant_id    (grant_id_s),
        .next_ptr    (next_ptr_s),
        .grant_valid (grant_valid_s)
    );

    assign fifo_pop = grant_s;

    // Output link register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_vc    <= '0;
            out_data  <= '0;
            rr_ptr_r  <= '0;
        end else begin
            out_valid <= grant_valid_s;
            if (grant_valid_s) begin
                out_vc   <= grant_id_s;
                out_data <= fifo_data[grant_id_s*DATA_W +: DATA_W];
                rr_ptr_r <= next_ptr_s;
            end
        end
    end

    // Per-VC credit counters; a return into a full counter saturates and
    // latches the sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_err <= 1'b0;
            for (int k = 0; k < NUM_VC; k++) begin
                credit_r[k] <= CRED_W'(CREDIT_DEPTH);
            end
        end else begin
            for (int k = 0; k < NUM_VC; k++) begin
                case ({grant_s[k], credit_in[k]})
                    2'b10:   credit_r[k] <= credit_r[k] - CRED_W'(1);
                    2'b01: begin
                        if (credit_r[k] == CRED_W'(CREDIT_DEPTH)) begin
                            credit_err <= 1'b1;
                        end else begin
                            credit_r[k] <= credit_r[k] + CRED_W'(1);
                        end
                    end
                    default: credit_r[k] <= credit_r[k];
                endcase
            end
        end
    end

`ifdef VC_SCHED_STARVE_CNT_EN
    logic [7:0] starve_cnt_r [NUM_VC];

    // Count cycles a VC could have gone but lost arbitration; saturates at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_VC; k++) begin
                starve_cnt_r[k] <= 8'd0;
            end
        end else begin
            for (int k = 0; k < NUM_VC; k++) begin
                if (grant_s[k]) begin
                    starve_cnt_r[k] <= 8'd0;
                end else if (eligible_s[k] && (starve_cnt_r[k] != 8'hFF)) begin
                    starve_cnt_r[k] <= starve_cnt_r[k] + 8'd1;
                end
            end
        end
    end

    // Flag a VC once it has waited longer than a full round-robin sweep allows.
    always_comb begin
        starve_flag = '0;
        for (int k = 0; k < NUM_VC; k++) begin
            starve_flag[k] = (starve_cnt_r[k] >= 8'(2 * NUM_VC));
        end
    end
`endif

endmodule

// File: tb/tb_vc_fifo_scheduler.sv
module tb_vc_fifo_scheduler;

    localparam int NV = 4;
    localparam int CD = 8;
    localparam int DW = 32;
    localparam int VW = $clog2(NV);

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [NV-1:0]     fifo_empty;
    logic [NV*DW-1:0]  fifo_data;
    logic [NV-1:0]     fifo_pop;
    logic [NV-1:0]     credit_in;
    logic              out_valid;
    logic [VW-1:0]     out_vc;
    logic [DW-1:0]     out_data;
    logic              credit_err;
`ifdef VC_SCHED_STARVE_CNT_EN
    logic [NV-1:0]     starve_flag;
`endif

    vc_fifo_scheduler #(.NUM_VC(NV), .CREDIT_DEPTH(CD), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .credit_in  (credit_in),
        .out_valid  (out_valid),
        .out_vc     (out_vc),
        .out_data   (out_data),
        .credit_err (credit_err)
`ifdef VC_SCHED_STARVE_CNT_EN
        ,
        .starve_flag(starve_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [VW-1:0] vc;
        logic [DW-1:0] d;
        logic          err;
    } rec_t;

    rec_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int            m_cred [NV];
    int            m_ptr;
    logic          m_err;
    logic [VW-1:0] m_vc;
    logic [DW-1:0] m_data;
    logic [DW-1:0] head [NV];
    int            pops_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: one expected record per clock edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            rec_t r;
            r = sb.pop_front();
            check("out_valid", 64'(out_valid), 64'(r.v));
            check("out_vc", 64'(out_vc), 64'(r.vc));
            check("out_data", 64'(out_data), 64'(r.d));
            check("credit_err", 64'(credit_err), 64'(r.err));
        end
    end

    // drive one cycle, check the combinational pop, advance the model
    task automatic step(input logic r, input logic en, input logic [NV-1:0] emp,
                        input logic [NV-1:0] cin);
        int   win;
        rec_t rec;
        logic [NV-1:0] exp_pop;
        reset      = r;
        enable     = en;
        fifo_empty = emp;
        credit_in  = cin;
        for (int k = 0; k < NV; k++) fifo_data[k*DW +: DW] = head[k];
        #1;
        win = -1;
        if (!r && en) begin
            for (int i = 0; i < NV; i++) begin
                int k;
                k = (m_ptr + i) % NV;
                if (win < 0 && !emp[k] && m_cred[k] > 0) win = k;
            end
        end
        exp_pop = '0;
        if (win >= 0) exp_pop[win] = 1'b1;
        check("fifo_pop", 64'(fifo_pop), 64'(exp_pop));
        if (r) begin
            for (int k = 0; k < NV; k++) m_cred[k] = CD;
            m_ptr  = 0;
            m_err  = 1'b0;
            m_vc   = '0;
            m_data = '0;
            rec.v  = 1'b0;
        end else begin
            for (int k = 0; k < NV; k++) begin
                if (k == win && !cin[k]) m_cred[k]--;
                else if (k != win && cin[k]) begin
                    if (m_cred[k] == CD) m_err = 1'b1;
                    else m_cred[k]++;
                end
            end
            if (win >= 0) begin
                m_ptr  = (win + 1) % NV;
                m_vc   = VW'(win);
                m_data = head[win];
                rec.v  = 1'b1;
                pops_seen++;
            end else begin
                rec.v = 1'b0;
            end
        end
        rec.vc  = m_vc;
        rec.d   = m_data;
        rec.err = m_err;
        sb.push_back(rec);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; fifo_empty = '1; credit_in = '0; fifo_data = '0;
        pops_seen = 0;
        m_ptr = 0; m_err = 1'b0; m_vc = '0; m_data = '0;
        for (int k = 0; k < NV; k++) begin
            m_cred[k] = CD;
            head[k]   = DW'(32'hA0 + k);
        end
        @(negedge clk);

        // reset then idle with all FIFOs empty
        step(1'b1, 1'b0, 4'hF, 4'h0);
        step(1'b1, 1'b0, 4'hF, 4'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'hF, 4'h0);

        // all VCs busy: rotation 0,1,2,3,0,1,2,3
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'h0, 4'h0);

        // only VC2: drain its 8 credits, then one credit return gives one grant
        step(1'b1, 1'b0, 4'hF, 4'h0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4'b1011, 4'h0);
        step(1'b0, 1'b1, 4'b1011, 4'b0100);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b1011, 4'h0);

        // VC1: down to 5 credits, grant plus return holds at 5, then 5 more grants
        step(1'b1, 1'b0, 4'hF, 4'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b1101, 4'h0);
        step(1'b0, 1'b1, 4'b1101, 4'b0010);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 4'b1101, 4'h0);

        // credit return into a full counter: sticky error, cleared by reset
        step(1'b1, 1'b0, 4'hF, 4'h0);
        step(1'b0, 1'b1, 4'hF, 4'b1000);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'hF, 4'h0);
        step(1'b1, 1'b0, 4'hF, 4'h0);
        step(1'b0, 1'b1, 4'hF, 4'h0);

        // enable low: no pops, credits still return
        step(1'b0, 1'b1, 4'b1110, 4'h0);
        step(1'b0, 1'b0, 4'h0, 4'b0001);
        step(1'b0, 1'b0, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'h0, 4'h0);

        // reset mid-stream with VC0 eligible
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b1110, 4'h0);
        step(1'b1, 1'b1, 4'b1110, 4'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b1110, 4'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [NV-1:0] emp, cin;
            for (int k = 0; k < NV; k++) begin
                head[k] = $urandom;
                emp[k]  = ($urandom_range(0, 9) < 3);
                cin[k]  = ($urandom_range(0, 9) < 2);
            end
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), emp, cin);
        end

        @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        n_checks++;
        if (pops_seen < 100) begin
            n_fail++;
            $display("FAIL pop_activity: got %0d pops expected at least 100", pops_seen);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
